agrupate_lanes: RTL

- Successor to the result-grouping stage at the output of the compute pipeline. Each input beat carries up to LANES unique result values, each with a G-bit scatter mask.
- The block scatters each value into every output position its mask selects, and assembles full GROUP_SIZE-wide groups.
- Complete groups are buffered in an output FIFO. Groups are counted per iteration, and `done` pulses when the configured job ends.

---
 rtl/agrupate_pkg.sv | 19 +
 rtl/agrupate_fifo.sv | 53 +++++
 rtl/agrupate_lanes.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/agrupate_pkg.sv
// agrupate_pkg: shared FSM state type and slot layout constants for agrupate_lanes
package agrupate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_GROUP_SIZE = 4;

    // One slot is {mask[G-1:0], value[DW-1:0]}
    localparam int SLOT_W    = DEF_GROUP_SIZE + DEF_DATA_WIDTH;
    localparam int VALUE_LSB = 0;
    localparam int MASK_LSB  = DEF_DATA_WIDTH;

endpackage

// File: rtl/agrupate_fifo.sv
// agrupate_fifo: synchronous group FIFO with occupancy count and async active-high reset
module agrupate_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    localparam logic [AW-1:0] PTR_ONE = 1;

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

    // Next storage, pointers (wrap naturally, depth is a power of 2) and count
    always_comb begin
        mem_d = mem_q;
        wr_d  = push ? wr_q + PTR_ONE : wr_q;
        rd_d  = pop ? rd_q + PTR_ONE : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push)
            mem_d[wr_q] = din;
    end

    // State registers, storage cleared on reset so the head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/agrupate_lanes.sv
// agrupate_lanes: scatter masked lane values into full groups, buffer them, count iterations;
// optional sticky mask-overlap flag when AGRUPATE_OVERLAP_CHECK_EN is defined
module agrupate_lanes
    import agrupate_pkg::*;
#(
    parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
    parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
    parameter int LANES                  = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       configure,
    input  logic [LOG_MAX_ITERS-1:0]                   num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]          num_reads_per_iter,
    input  logic [LANES*(GROUP_SIZE+DATA_WIDTH)-1:0]   data_in,
    input  logic                                       valid_in,
    output logic                                       avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0]           data_out,
    output logic                                       valid_out,
    input  logic                                       avail_in,
    output logic                                       busy,
    output logic                                       done
`ifdef AGRUPATE_OVERLAP_CHECK_EN
    ,
    output logic                                       overlap_err
`endif
);

    localparam int G  = GROUP_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int SW = G + DW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]                     FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [LOG_MAX_ITERS-1:0]          IT_ONE   = 1;
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] RD_ONE   = 1;

    state_t                              state_q, state_d;
    logic [LOG_MAX_ITERS-1:0]            niters_q, niters_d, iter_q, iter_d;
    logic [LOG_MAX_READS_PER_ITER-1:0]   nreads_q, nreads_d, read_q, read_d;
    logic [G-1:0]                        cov_q, cov_d, cov_new;
    logic [G-1:0][DW-1:0]                grp_q, grp_d;
    logic                                accept, push, pop, last_read, last_iter;
    logic [CW-1:0]                       fifo_cnt;
    logic [G*DW-1:0]                     fifo_dout;

    assign avail_out = (state_q == RUN) && (fifo_cnt < FULL_CNT);
    assign accept    = valid_in && avail_out;
    assign valid_out = fifo_cnt != '0;
    assign pop       = valid_out && avail_in;
    assign push      = accept && (&cov_new);
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign data_out  = fifo_dout;
    assign last_read = read_q == nreads_q - RD_ONE;
    assign last_iter = iter_q == niters_q - IT_ONE;

    // Scatter: ascending lane order lets the higher lane win a contested position
    always_comb begin
        grp_d   = grp_q;
        cov_new = cov_q;
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                for (int j = 0; j < G; j++)
                    if (data_in[k*SW + DW + j])
                        grp_d[j] = data_in[k*SW +: DW];
                cov_new = cov_new | data_in[k*SW + DW +: G];
            end
        end
        cov_d = push ? '0 : cov_new;
    end

    // Job FSM and per-iteration group counters
    always_comb begin
        state_d  = state_q;
        niters_d = niters_q;
        nreads_d = nreads_q;
        iter_d   = iter_q;
        read_d   = read_q;
        case (state_q)
            IDLE: begin
                if (configure) begin
                    niters_d = num_iters;
                    nreads_d = num_reads_per_iter;
                    iter_d   = '0;
                    read_d   = '0;
                    state_d  = (num_iters == '0 || num_reads_per_iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push) begin
                    read_d = last_read ? '0 : read_q + RD_ONE;
                    iter_d = last_read ? iter_q + IT_ONE : iter_q;
                    if (last_read && last_iter)
                        state_d = DRAIN;
                end
            end
            DRAIN: state_d = valid_out ? DRAIN : DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control, counter, coverage and group registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            niters_q <= '0;
            nreads_q <= '0;
            iter_q   <= '0;
            read_q   <= '0;
            cov_q    <= '0;
            grp_q    <= '0;
        end else begin
            state_q  <= state_d;
            niters_q <= niters_d;
            nreads_q <= nreads_d;
            iter_q   <= iter_d;
            read_q   <= read_d;
            cov_q    <= cov_d;
            grp_q    <= grp_d;
        end
    end

`ifdef AGRUPATE_OVERLAP_CHECK_EN
    logic         ovl_q, ovl_d, hit;
    logic [G-1:0] seen;

    // Overlap against prior coverage and against lower lanes of the same beat
    always_comb begin
        seen = cov_q;
        hit  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            hit  = hit | (|(seen & data_in[k*SW + DW +: G]));
            seen = seen | data_in[k*SW + DW +: G];
        end
        ovl_d = (state_q == IDLE && configure) ? 1'b0 : (ovl_q | (accept && hit));
    end

    // Sticky overlap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovl_q <= 1'b0;
        else
            ovl_q <= ovl_d;
    end

    assign overlap_err = ovl_q;
`endif

    agrupate_fifo #(
        .WIDTH (G*DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (grp_d),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

endmodule
